alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, multi-cycle successor to the single-cycle integer ALU. Executes the same eleven base RV32I operations with a one-cycle registered latency, adds the RV32M multiply/divide group as an iterative unit, and sits between issue and writeback behind valid/ready handshakes on both sides. Supports backpressure and synchronous flush.

## Interface
- XLEN, 32: datapath width. Power of two, 8 to 64.
- SHAMT_W, $clog2(XLEN): derived shift-amount width. Not overridable.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of any in-flight or pending result.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept this cycle.
- alu_op  in  5  operation code (alu_op_e).
- operand_a  in  XLEN  first operand.
- operand_b  in  XLEN  second operand / shift amount.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- alu_data  out  XLEN  registered result.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B. Encodings are unchanged from the current ALU.
  - 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU.
  - 19–31 complete as base ops with result 0.
- Shifts use operand_b[SHAMT_W-1:0] only. SRA fills with operand_a[XLEN-1].
- SLT/SLTU return 1 or 0, zero-extended to XLEN.
- Base op results are computed combinationally and registered at accept.
- Multiply: shift-add, one multiplier bit per cycle, XLEN iterations, 2·XLEN-bit accumulator on operand magnitudes, sign fixup on exit.
  - MUL returns the low half.
  - MULH, MULHSU and MULHU return the high half. MULHSU treats operand_a as signed and operand_b as unsigned.
- Divide: restoring, one quotient bit per cycle, XLEN iterations on magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide special cases, detected at accept and completed with base-op latency:
  - Divisor 0: quotient all-ones; remainder equals operand_a.
  - Signed overflow (most-negative / −1): quotient equals operand_a; remainder 0.
- FSM:
  - IDLE → DONE on accepting a base op or a special-case divide.
  - IDLE → CALC on accepting a multiply or divide.
  - CALC → DONE when the iteration counter reaches XLEN−1.
  - DONE → IDLE on out_ready without a new accept.
  - DONE → DONE or CALC on out_ready with a new accept in the same cycle.
- in_ready = !flush && (state==IDLE || (state==DONE && out_ready)).
- out_valid = (state==DONE).
- flush forces IDLE at the next edge from any state. No result from the aborted op is ever presented. A request offered in the flush cycle is not accepted.

## Timing
- Reset: state IDLE, out_valid 0, alu_data 0, iteration counter 0, accumulators 0. in_ready is 1 in the first cycle after reset deassertion.
- Cycle k is the accept cycle (in_valid && in_ready at its edge).
  - Base op or special-case divide: out_valid is first high in cycle k+1.
  - Multiply/divide: out_valid is first high in cycle k+XLEN+1.
- While out_valid && !out_ready: alu_data and out_valid hold stable, and in_ready is 0.
- Result handoff and new accept in the same cycle are legal; there are no bubbles between back-to-back base ops.
- Operands are captured at accept. Input changes during CALC have no effect.
- Reset during CALC or DONE returns all outputs to reset values asynchronously.
- Both flush and out_ready in DONE: the result counts as consumed and the state goes to IDLE.

## Structure
- Package alu_pkg holds:
  - alu_op_e (5-bit enum, values above) and alu_state_e (IDLE, CALC, DONE).
  - Helper functions is_muldiv() and is_div_special().
- Sub-module muldiv_iter contains the counter, accumulators, the shift-add/restoring datapath and sign fixup. Its interface: start, op, a, b, done, result.
- Base ops stay in the top module as one combinational case feeding the output register.

## Test plan
- ADD 0x7FFFFFFF+1 → 0x80000000 in cycle k+1; SRA 0x80000000 by 0x3F → 0xFFFFFFFF (SHAMT masking); SLT(−1,1) → 1; SLTU(0xFFFFFFFF,1) → 0; op 25 → 0.
- a=b=0xFFFFFFFF:
  - MUL → 1, MULH → 0, MULHU → 0xFFFFFFFE, MULHSU → 0xFFFFFFFF.
  - Each has out_valid first high in cycle k+33.
- DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 7/2 → 3; REMU 7/2 → 1. Latency 33.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. All in cycle k+1.
- ADD result with out_ready low for 5 cycles:
  - alu_data stable and in_ready 0 throughout.
  - Raising out_ready with in_valid (SUB 3−5) hands off, then presents 0xFFFFFFFE in the next cycle.
- Flush in cycle k+10 of a DIV → out_valid never rises and in_ready is 1 in cycle k+11. rst asserted mid-MUL → out_valid 0 and alu_data 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and decode helpers for the iterative ALU.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: alu_op_e (5-bit opcode), alu_state_e (control FSM), is_muldiv(), is_div_special().
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_PASS_B = 5'd10,
        OP_MUL    = 5'd11,
        OP_MULH   = 5'd12,
        OP_MULHSU = 5'd13,
        OP_MULHU  = 5'd14,
        OP_DIV    = 5'd15,
        OP_DIVU   = 5'd16,
        OP_REM    = 5'd17,
        OP_REMU   = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    // True for every op that belongs to the multiply/divide group.
    function automatic logic is_muldiv(input alu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                          OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    // Divides whose answer is fixed without iterating: divisor zero, or
    // signed most-negative / -1. Operand tests are precomputed by the caller
    // so the helper stays width-independent.
    function automatic logic is_div_special(input alu_op_e op,
                                            input logic    b_zero,
                                            input logic    a_min,
                                            input logic    b_neg_one);
        logic div_any;
        logic div_signed;
        div_any    = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        div_signed = op inside {OP_DIV, OP_REM};
        return div_any && (b_zero || (div_signed && a_min && b_neg_one));
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring) engine, one bit per cycle.
// Latency: XLEN cycles after start; done is high during the last iteration with result valid alongside.
// Backpressure: none; the caller holds off start until it can take the result, flush abandons the op.
// Ports: clk, rst (async high), flush, start (load operands), op, a, b, done, result.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    // hi/lo form the 2*XLEN accumulator. Multiply: lo starts as the multiplier
    // and drains out the bottom while the product fills in from the top.
    // Divide: hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [XLEN-1:0]  hi, lo, dvs;
    logic [CNT_W-1:0] cnt;
    logic             busy, is_div, sel_hi, neg_res;

    // Operand decode at start
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    assign a_sgn = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_sgn = op inside {OP_MULH, OP_DIV, OP_REM};
    assign a_neg = a_sgn && a[XLEN-1];
    assign b_neg = b_sgn && b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One iteration step
    logic [XLEN:0]   mul_sum, div_rs, div_diff;
    logic [XLEN-1:0] hi_n, lo_n;

    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
        div_rs   = {hi, lo[XLEN-1]};
        div_diff = div_rs - {1'b0, dvs};
        if (is_div) begin
            // Top bit of the difference is the borrow: set means the trial
            // subtraction failed and the shifted remainder is kept.
            if (!div_diff[XLEN]) begin
                hi_n = div_diff[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_n = div_rs[XLEN-1:0];
                lo_n = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign fixup applied to the post-final-step values so the result is
    // ready in the same cycle as done.
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   div_sel;

    always_comb begin
        prod     = {hi_n, lo_n};
        prod_fix = neg_res ? -prod : prod;
        div_sel  = sel_hi ? hi_n : lo_n;
        if (is_div)
            result = neg_res ? -div_sel : div_sel;
        else
            result = sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end

    assign done = busy && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            dvs     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            is_div  <= 1'b0;
            sel_hi  <= 1'b0;
            neg_res <= 1'b0;
        end else if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= '0;
            hi      <= '0;
            is_div  <= op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
            sel_hi  <= op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
            // Remainder follows the dividend; quotient and product follow the xor.
            neg_res <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
            if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
                lo  <= a_mag;
                dvs <= b_mag;
            end else begin
                lo  <= b_mag;
                dvs <= a_mag;
            end
        end else if (busy) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Integer ALU: RV32I base ops registered in one cycle, RV32M mul/div via iterative engine.
// Latency: base ops and special-case divides 1 cycle; multiply/divide XLEN+1 cycles.
// Backpressure: valid/ready both sides; a held result blocks in_ready; flush drops any op.
// Ports: clk, rst (async high), flush, in_valid/in_ready, alu_op, operand_a, operand_b,
//        out_valid/out_ready, alu_data (registered result).
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_data
);

    localparam int SHAMT_W = $clog2(XLEN);

    alu_op_e          op;
    alu_state_e       state, state_nxt;
    logic [SHAMT_W-1:0] shamt;
    logic             accept, special, md_start, md_done;
    logic             b_zero, a_min, b_ones;
    logic [XLEN-1:0]  base_res, md_result;

    assign op     = alu_op_e'(alu_op);
    assign shamt  = operand_b[SHAMT_W-1:0];
    assign b_zero = (operand_b == '0);
    assign a_min  = (operand_a == {1'b1, {(XLEN-1){1'b0}}});
    assign b_ones = &operand_b;

    assign in_ready  = !flush && (state == IDLE || (state == DONE && out_ready));
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign special   = is_div_special(op, b_zero, a_min, b_ones);
    assign md_start  = accept && is_muldiv(op) && !special;

    // Single-cycle results. Divide/remainder arms only matter for the
    // special cases; iterating mul/div ops take their result from the engine.
    always_comb begin
        base_res = '0;
        case (op)
            OP_ADD:          base_res = operand_a + operand_b;
            OP_SUB:          base_res = operand_a - operand_b;
            OP_SLL:          base_res = operand_a << shamt;
            OP_SLT:          base_res = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            OP_SLTU:         base_res = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            OP_XOR:          base_res = operand_a ^ operand_b;
            OP_SRL:          base_res = operand_a >> shamt;
            OP_SRA:          base_res = $unsigned($signed(operand_a) >>> shamt);
            OP_OR:           base_res = operand_a | operand_b;
            OP_AND:          base_res = operand_a & operand_b;
            OP_PASS_B:       base_res = operand_b;
            OP_DIV, OP_DIVU: base_res = b_zero ? '1 : operand_a;
            OP_REM, OP_REMU: base_res = b_zero ? operand_a : '0;
            default:         base_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = md_start ? CALC : DONE;
                else if (state == DONE && out_ready)
                    state_nxt = IDLE;
            end
            CALC:    if (md_done) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            alu_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !md_start)
                alu_data <= base_res;
            else if (state == CALC && md_done && !flush)
                alu_data <= md_result;
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (md_start),
        .op     (op),
        .a      (operand_a),
        .b      (operand_b),
        .done   (md_done),
        .result (md_result)
    );

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: directed vector table, randomized ops against a reference
// model, and hand sequences for backpressure, flush and mid-operation reset.
module tb_alu_iter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [4:0]      alu_op = '0;
    logic [XLEN-1:0] operand_a = '0;
    logic [XLEN-1:0] operand_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] alu_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_iter #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_data  (alu_data)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model straight from the arithmetic definitions.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'($signed(a) >>> b[4:0]);
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd11: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            5'd12: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
            5'd13: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
            5'd14: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            5'd15: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            5'd16: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd17: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            5'd18: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic iter;
        iter = (op >= 5'd11) && (op <= 5'd18);
        if (op >= 5'd15 && op <= 5'd18) begin
            if (b == 0) iter = 1'b0;
            if ((op == 5'd15 || op == 5'd17) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                iter = 1'b0;
        end
        return iter ? XLEN + 1 : 1;
    endfunction

    // Offers one op and returns at the falling edge of cycle k+1 (k = accept cycle).
    task automatic accept_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        alu_op = op; operand_a = a; operand_b = b; in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 100) begin
            @(negedge clk); #1; guard++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", guard);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Issues one op with out_ready high; reports cycles until out_valid and the data.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
        lat = 0;
        res = 'x;
        accept_op(op, a, b);
        for (int n = 1; n <= 100; n++) begin
            if (out_valid) begin
                lat = n;
                res = alu_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] res, held, ra, rb;
        logic [4:0]  rop;

        vecs.push_back(vec_t'{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1});
        vecs.push_back(vec_t'{5'd7,  32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF, 1});
        vecs.push_back(vec_t'{5'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1});
        vecs.push_back(vec_t'{5'd4,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1});
        vecs.push_back(vec_t'{5'd25, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1});
        vecs.push_back(vec_t'{5'd2,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1});
        vecs.push_back(vec_t'{5'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1});
        vecs.push_back(vec_t'{5'd10, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hCAFE_F00D, 1});
        vecs.push_back(vec_t'{5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33});
        vecs.push_back(vec_t'{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33});
        vecs.push_back(vec_t'{5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back(vec_t'{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
        vecs.push_back(vec_t'{5'd15, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
        vecs.push_back(vec_t'{5'd17, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
        vecs.push_back(vec_t'{5'd16, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 33});
        vecs.push_back(vec_t'{5'd18, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 33});
        vecs.push_back(vec_t'{5'd15, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1});
        vecs.push_back(vec_t'{5'd17, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1});
        vecs.push_back(vec_t'{5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back(vec_t'{5'd17, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});
        vecs.push_back(vec_t'{5'd16, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1});
        vecs.push_back(vec_t'{5'd18, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1});

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_alu_data", alu_data, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
            check($sformatf("vec%0d_op%0d_data", i, vecs[i].op), res, vecs[i].exp);
            check($sformatf("vec%0d_op%0d_lat", i, vecs[i].op), 32'(lat), 32'(vecs[i].lat));
        end

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            rop = (i % 2 == 0) ? 5'($urandom_range(11, 18)) : 5'($urandom_range(0, 31));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(rop, ra, rb, lat, res);
            check($sformatf("rand%0d_op%0d_data", i, rop), res, ref_alu(rop, ra, rb));
            check($sformatf("rand%0d_op%0d_lat", i, rop), 32'(lat), 32'(ref_lat(rop, ra, rb)));
        end

        // Backpressure: ADD held for 5 cycles, then handoff with SUB accepted same cycle
        @(negedge clk);
        out_ready = 1'b0;
        accept_op(5'd0, 32'd100, 32'd23);
        held = 32'd123;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("hold%0d_out_valid", c), {31'b0, out_valid}, 32'd1);
            check($sformatf("hold%0d_alu_data", c), alu_data, held);
            check($sformatf("hold%0d_in_ready", c), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        alu_op = 5'd1; operand_a = 32'd3; operand_b = 32'd5; in_valid = 1'b1;
        #1;
        check("handoff_in_ready", {31'b0, in_ready}, 32'd1);
        check("handoff_old_data", alu_data, held);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("handoff_sub_valid", {31'b0, out_valid}, 32'd1);
        check("handoff_sub_data", alu_data, 32'hFFFF_FFFE);

        // Flush in cycle k+10 of a DIV
        accept_op(5'd15, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_cycle_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("after_flush_in_ready", {31'b0, in_ready}, 32'd1);
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            check("flush_no_out_valid", {31'b0, seen}, 32'd0);
        end

        // Reset in the middle of a multiply
        run_op(5'd0, 32'd5, 32'd6, lat, res);
        check("pre_reset_add", res, 32'd11);
        accept_op(5'd11, 32'd1234, 32'd5678);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midmul_reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("midmul_reset_alu_data", alu_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_in_ready", {31'b0, in_ready}, 32'd1);
        run_op(5'd11, 32'd1234, 32'd5678, lat, res);
        check("post_reset_mul", res, 32'd7006652);
        check("post_reset_mul_lat", 32'(lat), 32'd33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
